// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive buffer controller.
// Holds state encodings, trigger-level codes and the layout of a FIFO entry.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    TRIG_1         = 2'b00,
    TRIG_4         = 2'b01,
    TRIG_8         = 2'b10,
    TRIG_NEAR_FULL = 2'b11
  } trig_level_e;

  localparam int ENTRY_W     = 10;
  localparam int RD_DATA_LSB = 0;
  localparam int RD_DATA_MSB = 7;
  localparam int RD_PE_BIT   = 8;
  localparam int RD_FE_BIT   = 9;

  // Occupancy at which the data interrupt asserts.
  function automatic int trig_threshold(input logic [1:0] lvl, input int depth);
    case (lvl)
      TRIG_1:  return 1;
      TRIG_4:  return 4;
      TRIG_8:  return 8;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received characters: storage, wrapping pointers,
// occupancy count and registered read port.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic [AW:0]        count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic [ENTRY_W-1:0] rd_data_q;
  logic               rd_valid_q;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

  // Flush beats both ports; a pop frees the slot a full-time push needs.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (flush_i)                count_d = '0;
    else if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= do_pop;
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop) begin
          rd_ptr_q  <= rd_ptr_q + 1'b1;
          rd_data_q <= mem_q[rd_ptr_q];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Receive-side controller: gates the Rx engine, buffers completed characters
// with their error flags, and raises data/timeout/error interrupts.
module uart_rx_buffer_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               Enable,
  input  logic               Flush,
  input  logic               ErrClr,
  input  logic [1:0]         TrigLevel,
  input  logic               RxDone,
  input  logic               RxBusy,
  input  logic               RxTimeOut,
  input  logic               ParityError,
  input  logic               FrameError,
  input  logic [7:0]         RxData,
  output logic               RxEn,
  input  logic               RdReq,
  output logic [ENTRY_W-1:0] RdData,
  output logic               RdValid,
  output logic [AW:0]        Count,
  output logic               Empty,
  output logic               Full,
  output logic               Overrun,
  output logic               IrqData,
  output logic               IrqTimeout,
  output logic               IrqErr,
  output logic [1:0]         DbgState
);

  ctrl_state_e        state_q, state_d;
  logic               rx_done_q, rx_to_q;
  logic               overrun_q, overrun_d;
  logic               irq_data_q, irq_data_d;
  logic               irq_to_q, irq_to_d;
  logic               irq_err_q, irq_err_d;
  logic               push_stb, pop_fire, to_rise, ovr_set, err_set;
  logic [ENTRY_W-1:0] wr_entry;
  logic [AW:0]        thr;

  // Pop handshake: RdReq is a request with no ready; it is honoured whenever the
  // FIFO is non-empty and no Flush is present, answered by a one-cycle RdValid.
  assign push_stb = RxDone & ~rx_done_q & (state_q != ST_OFF);
  assign pop_fire = RdReq & ~Empty & ~Flush;
  assign to_rise  = RxTimeOut & ~rx_to_q;
  assign ovr_set  = push_stb & ~Flush & Full & ~RdReq;
  assign err_set  = (push_stb & ~Flush & (ParityError | FrameError)) | ovr_set;
  assign thr      = (AW+1)'(trig_threshold(TrigLevel, DEPTH));

  always_comb begin
    wr_entry                          = '0;
    wr_entry[RD_DATA_MSB:RD_DATA_LSB] = RxData;
    wr_entry[RD_PE_BIT]               = ParityError;
    wr_entry[RD_FE_BIT]               = FrameError;
  end

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RESETn),
    .push_i     (push_stb),
    .pop_i      (RdReq),
    .flush_i    (Flush),
    .wr_data_i  (wr_entry),
    .rd_data_o  (RdData),
    .rd_valid_o (RdValid),
    .count_o    (Count),
    .empty_o    (Empty),
    .full_o     (Full)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= ST_OFF;
    else         state_q <= state_d;
  end

  // STOP keeps the engine enabled until the in-flight frame finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (Enable) state_d = ST_RUN;
      ST_RUN:  if (!Enable) state_d = RxBusy ? ST_STOP : ST_OFF;
      ST_STOP: begin
        if (Enable)       state_d = ST_RUN;
        else if (!RxBusy) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    RxEn = 1'b0;
    if (state_q != ST_OFF) RxEn = 1'b1;
  end

  always_comb begin
    overrun_d = overrun_q;
    if (Flush)        overrun_d = 1'b0;
    else if (ovr_set) overrun_d = 1'b1;
    else if (ErrClr)  overrun_d = 1'b0;

    irq_err_d = irq_err_q;
    if (err_set)     irq_err_d = 1'b1;
    else if (ErrClr) irq_err_d = 1'b0;

    irq_to_d = irq_to_q;
    if (Flush || pop_fire || state_q == ST_OFF) irq_to_d = 1'b0;
    else if (to_rise && Count != '0)            irq_to_d = 1'b1;

    irq_data_d = (Count >= thr);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_done_q  <= 1'b0;
      rx_to_q    <= 1'b0;
      overrun_q  <= 1'b0;
      irq_err_q  <= 1'b0;
      irq_to_q   <= 1'b0;
      irq_data_q <= 1'b0;
    end else begin
      rx_done_q  <= RxDone;
      rx_to_q    <= RxTimeOut;
      overrun_q  <= overrun_d;
      irq_err_q  <= irq_err_d;
      irq_to_q   <= irq_to_d;
      irq_data_q <= irq_data_d;
    end
  end

  assign Overrun    = overrun_q;
  assign IrqErr     = irq_err_q;
  assign IrqTimeout = irq_to_q;
  assign IrqData    = irq_data_q;
  assign DbgState   = state_q;

endmodule
